// File: rtl/alu_ctrl_if.sv
// ALU control handshake bundle.
// Upstream instruction side plus ALU-stage result side.
interface alu_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] aluop;
  logic [5:0] funct;
  logic [5:0] opcode;
  logic [3:0] selector;
  logic       out_valid;
  logic       out_ready;
  logic       illegal;
  logic       busy;

  modport master (
    output in_valid, aluop, funct, opcode, out_ready,
    input  in_ready, selector, out_valid, illegal, busy
  );

  modport slave (
    input  in_valid, aluop, funct, opcode, out_ready,
    output in_ready, selector, out_valid, illegal, busy
  );
endinterface

// File: rtl/alu_ctrl.sv
// ALU control decode with registered selector,
// valid/ready handshake and multi-cycle MUL/DIV latency.
module alu_ctrl #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 8
) (
  input logic       clk,
  input logic       reset,
  alu_ctrl_if.slave bus
);
  localparam logic [3:0] S_AND  = 4'b0000;
  localparam logic [3:0] S_OR   = 4'b0001;
  localparam logic [3:0] S_ADD  = 4'b0010;
  localparam logic [3:0] S_PASS = 4'b0011;
  localparam logic [3:0] S_XOR  = 4'b0101;
  localparam logic [3:0] S_SUB  = 4'b0110;
  localparam logic [3:0] S_SLT  = 4'b0111;
  localparam logic [3:0] S_MUL  = 4'b1000;
  localparam logic [3:0] S_DIV  = 4'b1010;
  localparam logic [3:0] S_NOR  = 4'b1100;

  localparam logic [3:0] MUL_N = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_N = 4'(DIV_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } state_t;

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [3:0] sel_q, sel_n;
  logic       ill_q, ill_n;
  logic [3:0] dec_sel;
  logic [3:0] dec_n;
  logic       dec_ill;
  logic       accept;

  assign bus.in_ready = !reset &&
    (state == IDLE || (state == HOLD && bus.out_ready));
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.busy      = (state == WAIT);
  assign bus.out_valid = (state == HOLD);
  assign bus.selector  = sel_q;
  assign bus.illegal   = ill_q;

  // decode the presented instruction into selector, legality, latency
  always_comb begin
    dec_sel = S_PASS;
    dec_ill = 1'b0;
    dec_n   = 4'd1;
    unique case (bus.aluop)
      2'b00: dec_sel = S_ADD;
      2'b01: dec_sel = S_SUB;
      2'b10: begin
        case (bus.funct)
          6'b100000, 6'b100001: dec_sel = S_ADD;
          6'b100010, 6'b100011: dec_sel = S_SUB;
          6'b100100: dec_sel = S_AND;
          6'b100101: dec_sel = S_OR;
          6'b100110: dec_sel = S_XOR;
          6'b100111: dec_sel = S_NOR;
          6'b101010: dec_sel = S_SLT;
          6'b011000: begin
            dec_sel = S_MUL;
            dec_n   = MUL_N;
          end
          6'b011010: begin
            dec_sel = S_DIV;
            dec_n   = DIV_N;
          end
          default: dec_ill = 1'b1;
        endcase
      end
      2'b11: begin
        case (bus.opcode)
          6'b001000, 6'b001001: dec_sel = S_ADD;
          6'b001100: dec_sel = S_AND;
          6'b001101: dec_sel = S_OR;
          6'b001110: dec_sel = S_XOR;
          6'b001010: dec_sel = S_SLT;
          6'b001111: dec_sel = S_PASS;
          default:   dec_ill = 1'b1;
        endcase
      end
    endcase
  end

  // next state: accept, count down multi-cycle ops, retire results
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sel_n   = sel_q;
    ill_n   = ill_q;
    unique case (state)
      IDLE, HOLD: begin
        if (accept) begin
          sel_n = dec_sel;
          ill_n = dec_ill;
          if (dec_n > 4'd1) begin
            state_n = WAIT;
            cnt_n   = dec_n - 4'd1;
          end else begin
            state_n = HOLD;
            cnt_n   = 4'd0;
          end
        end else if (state == HOLD && bus.out_ready) begin
          state_n = IDLE;
        end
      end
      WAIT: begin
        if (cnt <= 4'd1) begin
          state_n = HOLD;
          cnt_n   = 4'd0;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 4'd0;
      end
    endcase
  end

  // state register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      sel_q <= 4'd0;
      ill_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sel_q <= sel_n;
      ill_q <= ill_n;
    end
  end
endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: vector table, directed
// latency/stall/reset sequences, random traffic vs model.
module tb_alu_ctrl;
  localparam int MULN = 4;
  localparam int DIVN = 8;

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_PASS = 4'b0011;
  localparam logic [3:0] C_XOR  = 4'b0101;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SLT  = 4'b0111;
  localparam logic [3:0] C_MUL  = 4'b1000;
  localparam logic [3:0] C_DIV  = 4'b1010;
  localparam logic [3:0] C_NOR  = 4'b1100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_ctrl_if bus();

  alu_ctrl #(
    .MUL_CYCLES(MULN),
    .DIV_CYCLES(DIVN)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [5:0] rc[11] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                         6'h25, 6'h26, 6'h27, 6'h2A, 6'h18, 6'h1A};
  logic [3:0] rs[11] = '{C_ADD, C_ADD, C_SUB, C_SUB, C_AND,
                         C_OR, C_XOR, C_NOR, C_SLT, C_MUL, C_DIV};
  logic [5:0] ic[7] = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0F};
  logic [3:0] isl[7] = '{C_ADD, C_ADD, C_AND, C_OR, C_XOR, C_SLT, C_PASS};

  // reference model: one outstanding result and the edge it becomes valid
  bit         m_pend = 0;
  int         m_ready_at = 0;
  logic [3:0] m_sel = 4'd0;
  bit         m_ill = 0;
  int         ecount = 0;

  typedef struct {
    logic [1:0] a;
    logic [5:0] f;
    logic [5:0] o;
    logic [3:0] s;
    bit         il;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0h expected %0h",
               name, ecount, act, exp);
    end
  endtask

  function automatic void ref_decode(
    input  logic [1:0] a,
    input  logic [5:0] f,
    input  logic [5:0] o,
    output logic [3:0] s,
    output bit         il,
    output int         n
  );
    s  = C_PASS;
    il = 1;
    n  = 1;
    if (a == 2'b00) begin
      s  = C_ADD;
      il = 0;
    end else if (a == 2'b01) begin
      s  = C_SUB;
      il = 0;
    end else if (a == 2'b10) begin
      foreach (rc[i]) if (rc[i] == f) begin
        s  = rs[i];
        il = 0;
      end
    end else begin
      foreach (ic[i]) if (ic[i] == o) begin
        s  = isl[i];
        il = 0;
      end
    end
    if (s == C_MUL) n = MULN;
    if (s == C_DIV) n = DIVN;
  endfunction

  // one clock: drive at negedge, check in_ready, clock, check outputs
  task automatic step(
    input  bit         rst,
    input  bit         iv,
    input  logic [1:0] a,
    input  logic [5:0] f,
    input  logic [5:0] o,
    input  bit         ordy,
    output bit         acc
  );
    logic [3:0] s;
    bit         il;
    int         n;
    bit         rdy;
    bit         was_valid;
    reset         = rst;
    bus.in_valid  = iv;
    bus.aluop     = a;
    bus.funct     = f;
    bus.opcode    = o;
    bus.out_ready = ordy;
    #1;
    was_valid = m_pend && ecount >= m_ready_at;
    rdy = !rst && (!m_pend || (was_valid && ordy));
    chk("in_ready", bus.in_ready, rdy);
    acc = iv && rdy;
    ref_decode(a, f, o, s, il, n);
    @(posedge clk);
    ecount++;
    if (rst) begin
      m_pend = 0;
      m_sel  = 4'd0;
      m_ill  = 0;
    end else if (acc) begin
      m_pend     = 1;
      m_ready_at = ecount + n - 1;
      m_sel      = s;
      m_ill      = il;
    end else if (was_valid && ordy) begin
      m_pend = 0;
    end
    @(negedge clk);
    chk("out_valid", bus.out_valid, m_pend && ecount >= m_ready_at);
    chk("busy", bus.busy, m_pend && ecount < m_ready_at);
    chk("selector", bus.selector, m_sel);
    if (m_pend && ecount >= m_ready_at)
      chk("illegal", bus.illegal, m_ill);
  endtask

  initial begin
    bit         acc;
    bit         have;
    bit         iv;
    bit         rst;
    bit         ordy;
    logic [1:0] ca;
    logic [5:0] cf;
    logic [5:0] co;

    tbl[0] = '{2'b10, 6'h22, 6'h00, C_SUB,  1'b0};
    tbl[1] = '{2'b11, 6'h00, 6'h0D, C_OR,   1'b0};
    tbl[2] = '{2'b00, 6'h3F, 6'h3F, C_ADD,  1'b0};
    tbl[3] = '{2'b01, 6'h00, 6'h00, C_SUB,  1'b0};
    tbl[4] = '{2'b10, 6'h3F, 6'h00, C_PASS, 1'b1};
    tbl[5] = '{2'b11, 6'h00, 6'h03, C_PASS, 1'b1};
    tbl[6] = '{2'b10, 6'h27, 6'h00, C_NOR,  1'b0};
    tbl[7] = '{2'b11, 6'h00, 6'h0F, C_PASS, 1'b0};
    tbl[8] = '{2'b10, 6'h2A, 6'h00, C_SLT,  1'b0};
    tbl[9] = '{2'b11, 6'h00, 6'h0E, C_XOR,  1'b0};

    // reset, with an instruction offered that must not be taken
    step(1, 1, 2'b00, 6'h0, 6'h0, 1, acc);
    step(1, 1, 2'b00, 6'h0, 6'h0, 1, acc);
    chk("rst_sel", bus.selector, 4'd0);
    chk("rst_ov", bus.out_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_ill", bus.illegal, 1'b0);

    // back-to-back single-cycle ops, one result per cycle
    foreach (tbl[i]) begin
      step(0, 1, tbl[i].a, tbl[i].f, tbl[i].o, 1, acc);
      chk("tbl_acc", acc, 1'b1);
      chk("tbl_ov", bus.out_valid, 1'b1);
      chk("tbl_sel", bus.selector, tbl[i].s);
      chk("tbl_ill", bus.illegal, tbl[i].il);
    end
    step(0, 0, 2'b00, 6'h0, 6'h0, 1, acc);
    chk("drain_ov", bus.out_valid, 1'b0);
    chk("drain_sel_kept", bus.selector, C_XOR);

    // DIV latency: seven busy cycles, result in the eighth
    step(0, 1, 2'b10, 6'h1A, 6'h0, 1, acc);
    for (int k = 1; k <= DIVN - 1; k++) begin
      chk("div_busy", bus.busy, 1'b1);
      chk("div_ready", bus.in_ready, 1'b0);
      chk("div_sel", bus.selector, C_DIV);
      if (k < DIVN - 1) step(0, 0, 2'b00, 6'h0, 6'h0, 1, acc);
    end
    step(0, 0, 2'b00, 6'h0, 6'h0, 1, acc);
    chk("div_ov", bus.out_valid, 1'b1);
    chk("div_res", bus.selector, C_DIV);
    step(0, 0, 2'b00, 6'h0, 6'h0, 1, acc);

    // stall: result held while downstream is not ready
    step(0, 1, 2'b00, 6'h0, 6'h0, 0, acc);
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 2'b01, 6'h0, 6'h0, 0, acc);
      chk("stall_sel", bus.selector, C_ADD);
      chk("stall_ov", bus.out_valid, 1'b1);
    end
    step(0, 1, 2'b01, 6'h0, 6'h0, 1, acc);
    chk("stall_next", bus.selector, C_SUB);
    step(0, 0, 2'b00, 6'h0, 6'h0, 1, acc);

    // reset in the third cycle of a MUL aborts it
    step(0, 1, 2'b10, 6'h18, 6'h0, 1, acc);
    step(0, 0, 2'b00, 6'h0, 6'h0, 1, acc);
    chk("mul_busy", bus.busy, 1'b1);
    step(1, 0, 2'b00, 6'h0, 6'h0, 1, acc);
    chk("abort_ov", bus.out_valid, 1'b0);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_sel", bus.selector, 4'd0);
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 2'b00, 6'h0, 6'h0, 1, acc);
      chk("abort_none", bus.out_valid, 1'b0);
    end

    // random traffic; upstream holds an instruction until taken
    have = 0;
    ca = 2'b00;
    cf = 6'h0;
    co = 6'h0;
    for (int c = 0; c < 600; c++) begin
      rst  = ($urandom_range(0, 59) == 0);
      ordy = ($urandom_range(0, 3) != 0);
      if (have) begin
        iv = 1;
      end else begin
        iv = ($urandom_range(0, 3) != 0);
        ca = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 3) != 0) cf = rc[$urandom_range(0, 10)];
        else cf = 6'($urandom);
        if ($urandom_range(0, 3) != 0) co = ic[$urandom_range(0, 6)];
        else co = 6'($urandom);
      end
      step(rst, iv, ca, cf, co, ordy, acc);
      have = iv && !acc && !rst;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
- REQ-001: Parameter MUL_CYCLES, default 2; cycles from acceptance to out_valid for a MUL op; legal range 1..15.
- REQ-002: Parameter DIV_CYCLES, default 8; cycles from acceptance to out_valid for a DIV op; legal range 1..15.
- REQ-003: clk  input  1  single clock; all state updates on rising edge.
- REQ-004: reset  input  1  synchronous, active-high reset.
- REQ-005: in_valid  input  1  upstream presents an instruction.
- REQ-006: in_ready  output  1  block accepts an instruction this cycle.
- REQ-007: aluop  input  2  00 load/store, 01 branch, 10 R-type, 11 I-type.
- REQ-008: funct  input  6  R-type function field.
- REQ-009: opcode  input  6  I-type opcode field.
- REQ-010: selector  output  4  registered ALU operation code.
- REQ-011: out_valid  output  1  selector/illegal valid for the ALU stage.
- REQ-012: out_ready  input  1  ALU stage consumes the current result.
- REQ-013: illegal  output  1  accepted instruction had no legal decode; qualified by out_valid.
- REQ-014: busy  output  1  multi-cycle operation in progress.

Function
- REQ-015: Selector codes: AND 0000, OR 0001, ADD 0010, PASS 0011, XOR 0101, SUB 0110, SLT 0111, MUL 1000, DIV 1010, NOR 1100.
- REQ-016: aluop 00 -> ADD; aluop 01 -> SUB.
- REQ-017: aluop 10, funct: 100000/100001 ADD, 100010/100011 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT, 011000 MUL, 011010 DIV.
- REQ-018: aluop 11, opcode: 001000/001001 ADD, 001100 AND, 001101 OR, 001110 XOR, 001010 SLT, 001111 PASS (lui).
- REQ-019: Any other funct/opcode -> selector PASS, illegal=1; illegal is otherwise 0.
- REQ-020: States IDLE, WAIT, HOLD; a 4-bit down-counter serves WAIT.
- REQ-021: Acceptance = in_valid && in_ready on a rising edge; decode is captured into selector/illegal at that edge.
- REQ-022: in_ready = 1 in IDLE, = out_ready in HOLD, = 0 in WAIT.
- REQ-023: Single-cycle ops and illegal: IDLE/HOLD -> HOLD; out_valid=1 in the cycle after acceptance.
- REQ-024: MUL/DIV with N=MUL_CYCLES/DIV_CYCLES: out_valid rises exactly N cycles after the acceptance edge; N=1 behaves as single-cycle.
- REQ-025: For N>1, state WAIT; busy=1 and out_valid=0 for cycles 1..N-1 after acceptance; selector is stable at MUL/DIV throughout WAIT.
- REQ-026: HOLD: out_valid=1; selector/illegal held constant until out_valid && out_ready.
- REQ-027: HOLD with out_ready=1 and in_valid=1: back-to-back acceptance, no bubble; new decode replaces old at the same edge.
- REQ-028: HOLD with out_ready=1 and in_valid=0 -> IDLE, out_valid=0; selector keeps its last value.
- REQ-029: in_valid while in WAIT or while stalled in HOLD is ignored; upstream must hold its inputs.
- REQ-030: busy = (state == WAIT); out_valid = (state == HOLD).

Reset
- REQ-031: reset=1 at a rising edge forces IDLE, counter 0, selector 0000, out_valid 0, illegal 0, busy 0, regardless of state.
- REQ-032: While reset=1, in_ready=0 and no instruction is accepted.
- REQ-033: Reset during WAIT or HOLD aborts the operation; no out_valid is produced for it afterwards.

Verification
- REQ-034: out_ready=1; one-cycle pulses aluop=10/funct=100010, then aluop=11/opcode=001101 -> selector 0110 then 0001, each with out_valid in the cycle after acceptance, illegal=0.
- REQ-035: Defaults; aluop=10, funct=011010 -> busy=1 for 7 cycles, out_valid=1 with selector 1010 in cycle 8, in_ready=0 during WAIT.
- REQ-036: out_ready=0; accept aluop=00, then present aluop=01 for 5 cycles -> selector stays 0010 with out_valid=1; raise out_ready -> 0110 appears next cycle.
- REQ-037: aluop=10, funct=111111 and aluop=11, opcode=000011 -> each gives selector 0011, illegal=1, out_valid=1.
- REQ-038: Continuous in_valid, out_ready=1, 10 mixed single-cycle ops -> 10 results on 10 consecutive cycles, order preserved.
- REQ-039: Assert reset in cycle 3 of a MUL with MUL_CYCLES=4 -> next cycle out_valid=0, busy=0, selector 0000, and no result appears for that MUL.
